// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the multi-cycle ALU.
//   - 4-bit opcode map (OP_AND .. OP_MUL)
//   - controller state enum
//   - is_legal_op(): 1 for any opcode the ALU implements
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_SRL  = 4'b0100;
  localparam logic [3:0] OP_SRA  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_NOR  = 4'b1100;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SLL, OP_SRL, OP_SRA,
      OP_SUB, OP_SLT, OP_MUL, OP_SLTU, OP_NOR: is_legal_op = 1'b1;
      default:                                 is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative unsigned shift-add multiplier, one partial
// product per cycle for WIDTH cycles.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset (aborts a multiply)
//   start             load operands and begin (ignored while busy by the parent)
//   mcand_in/mplier_in operands sampled on start
//   done              high during the final iteration cycle
//   prod_hi/prod_lo   product after the current iteration; full product when done
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] mcand_in,
  input  logic [WIDTH-1:0] mplier_in,
  output logic             done,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] prod_lo
);

  localparam int CW = $clog2(WIDTH);

  logic             busy;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH:0]   sum;

  // acc_lo starts as the multiplier; each step adds the multiplicand on its
  // LSB and shifts the whole {carry, acc_hi, acc_lo} right by one.
  // Outputs present the post-step value so the parent can register the
  // final product on the same edge as the last iteration.
  always_comb begin
    sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
    prod_hi = sum[WIDTH:1];
    prod_lo = {sum[0], acc_lo[WIDTH-1:1]};
    done    = busy && (count == '0);
  end

  // count is a down-counter; terminal count 0 marks the last iteration.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      count  <= '0;
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      count  <= CW'(WIDTH - 1);
      mcand  <= mcand_in;
      acc_hi <= '0;
      acc_lo <= mplier_in;
    end else if (busy) begin
      acc_hi <= prod_hi;
      acc_lo <= prod_lo;
      count  <= count - CW'(1);
      if (count == '0) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshakes on operands and result.
// Single-cycle ops complete one cycle after accept; MUL takes WIDTH+1 cycles.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | ready for a new op (subject to result backpressure)
//   ST_MUL  | multiplier iterating; in_ready held low
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid/in_ready    operand handshake; A, B, Op sampled on accept
//   A, B, Op             operands and 4-bit opcode
//   out_valid/out_ready  result handshake; outputs held until taken
//   Result, ResultHi     result (ResultHi nonzero only for MUL)
//   Zero, Cout, Ovf, Err status flags registered with the result
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32  // power of two, >= 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       Op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] ResultHi,
  output logic             Zero,
  output logic             Cout,
  output logic             Ovf,
  output logic             Err
);

  localparam int SHW = $clog2(WIDTH);

  state_t           state, state_nxt;
  logic             accept;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_hi;
  logic [WIDTH-1:0] mul_lo;

  logic [WIDTH:0]   sum_add;
  logic [WIDTH:0]   sum_sub;
  logic             ovf_add;
  logic             ovf_sub;
  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] res_c;
  logic             cout_c;
  logic             ovf_c;
  logic             err_c;

  assign in_ready  = (state == ST_IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (Op == OP_MUL);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (mul_start) state_nxt = ST_MUL;
      ST_MUL:  if (mul_done)  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Subtraction is always computed since SLT/SLTU derive from it.
  always_comb begin
    sum_add = {1'b0, A} + {1'b0, B};
    sum_sub = {1'b0, A} + {1'b0, ~B} + (WIDTH+1)'(1);
    ovf_add = (A[WIDTH-1] == B[WIDTH-1])  && (sum_add[WIDTH-1] != A[WIDTH-1]);
    ovf_sub = (A[WIDTH-1] == ~B[WIDTH-1]) && (sum_sub[WIDTH-1] != A[WIDTH-1]);
    sh      = B[SHW-1:0];
    res_c   = '0;
    cout_c  = 1'b0;
    ovf_c   = 1'b0;
    err_c   = !is_legal_op(Op);
    case (Op)
      OP_AND:  res_c = A & B;
      OP_OR:   res_c = A | B;
      OP_NOR:  res_c = ~(A | B);
      OP_ADD: begin
        res_c  = sum_add[WIDTH-1:0];
        cout_c = sum_add[WIDTH];
        ovf_c  = ovf_add;
      end
      OP_SUB: begin
        res_c  = sum_sub[WIDTH-1:0];
        cout_c = sum_sub[WIDTH];
        ovf_c  = ovf_sub;
      end
      // N xor V gives the true signed ordering even when A-B overflows.
      OP_SLT:  res_c = {{(WIDTH-1){1'b0}}, sum_sub[WIDTH-1] ^ ovf_sub};
      // No carry out of A+~B+1 means a borrow, i.e. A < B unsigned.
      OP_SLTU: res_c = {{(WIDTH-1){1'b0}}, ~sum_sub[WIDTH]};
      OP_SLL:  res_c = A << sh;
      OP_SRL:  res_c = A >> sh;
      OP_SRA:  res_c = $unsigned($signed(A) >>> sh);
      default: res_c = '0;
    endcase
  end

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (mul_start),
    .mcand_in  (A),
    .mplier_in (B),
    .done      (mul_done),
    .prod_hi   (mul_hi),
    .prod_lo   (mul_lo)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      Result    <= '0;
      ResultHi  <= '0;
      Zero      <= 1'b1;
      Cout      <= 1'b0;
      Ovf       <= 1'b0;
      Err       <= 1'b0;
    end else if (accept && (Op != OP_MUL)) begin
      out_valid <= 1'b1;
      Result    <= res_c;
      ResultHi  <= '0;
      Zero      <= (res_c == '0);
      Cout      <= cout_c;
      Ovf       <= ovf_c;
      Err       <= err_c;
    end else if (mul_done) begin
      out_valid <= 1'b1;
      Result    <= mul_lo;
      ResultHi  <= mul_hi;
      Zero      <= (mul_lo == '0);
      Cout      <= 1'b0;
      Ovf       <= 1'b0;
      Err       <= 1'b0;
    end else if (out_valid && out_ready) begin
      // Covers a MUL accept draining the previous result too.
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed self-checking bench for alu_mc at WIDTH=32.
module tb_alu_mc;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A, B;
  logic [3:0]   Op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Result, ResultHi;
  logic         Zero, Cout, Ovf, Err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Op        (Op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Result    (Result),
    .ResultHi  (ResultHi),
    .Zero      (Zero),
    .Cout      (Cout),
    .Ovf       (Ovf),
    .Err       (Err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for in_ready, then presents the op for exactly one accept edge.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    check("issue_ready", 64'(in_ready), 64'd1);
    Op = op; A = a; B = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Single-cycle op: result is visible right after the accept edge.
  task automatic chk_alu(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp_res,
                         input logic exp_z, input logic exp_c, input logic exp_v);
    issue(op, a, b);
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_res"},   64'(Result),    64'(exp_res));
    check({tag, "_hi"},    64'(ResultHi),  64'd0);
    check({tag, "_zero"},  64'(Zero),      64'(exp_z));
    check({tag, "_cout"},  64'(Cout),      64'(exp_c));
    check({tag, "_ovf"},   64'(Ovf),       64'(exp_v));
    check({tag, "_err"},   64'(Err),       64'd0);
  endtask

  // MUL: counts cycles from the accept edge until out_valid, checking in_ready stays low.
  task automatic chk_mul(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                         input logic exp_z);
    int cyc = 1;
    logic rdy_seen = 1'b0;
    issue(OP_MUL, a, b);
    while (!out_valid && cyc < 100) begin
      if (in_ready) rdy_seen = 1'b1;
      tick();
      cyc++;
    end
    check({tag, "_latency"},  64'(cyc),      64'd33);
    check({tag, "_rdy_low"},  64'(rdy_seen), 64'd0);
    check({tag, "_lo"},       64'(Result),   64'(exp_lo));
    check({tag, "_hi"},       64'(ResultHi), 64'(exp_hi));
    check({tag, "_zero"},     64'(Zero),     64'(exp_z));
    check({tag, "_err"},      64'(Err),      64'd0);
  endtask

  initial begin
    int vcount;
    rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; Op = '0; out_ready = 1'b1;
    repeat (3) tick();
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_res",   64'(Result),    64'd0);
    check("rst_hi",    64'(ResultHi),  64'd0);
    check("rst_zero",  64'(Zero),      64'd1);
    check("rst_flags", 64'({Cout, Ovf, Err}), 64'd0);
    rst_n = 1'b1;
    tick();
    check("rst_ready", 64'(in_ready), 64'd1);

    //       tag     op       A             B             Result        Z     C     V
    chk_alu("add",   OP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b1);
    chk_alu("addc",  OP_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b0);
    chk_alu("sub0",  OP_SUB,  32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b1, 1'b0);
    chk_alu("subn",  OP_SUB,  32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
    chk_alu("subv",  OP_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1);
    chk_alu("slt",   OP_SLT,  32'h80000000, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0);
    chk_alu("sltu",  OP_SLTU, 32'h80000000, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0);
    chk_alu("sltu1", OP_SLTU, 32'h00000001, 32'h80000000, 32'h00000001, 1'b0, 1'b0, 1'b0);
    chk_alu("sra",   OP_SRA,  32'h80000000, 32'h0000001F, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    chk_alu("sll0",  OP_SLL,  32'h00000001, 32'h00000020, 32'h00000001, 1'b0, 1'b0, 1'b0);
    chk_alu("sll4",  OP_SLL,  32'h00000001, 32'h00000004, 32'h00000010, 1'b0, 1'b0, 1'b0);
    chk_alu("srl",   OP_SRL,  32'h80000000, 32'h00000004, 32'h08000000, 1'b0, 1'b0, 1'b0);
    chk_alu("and",   OP_AND,  32'hF0F01234, 32'h0FF0FFFF, 32'h00F01234, 1'b0, 1'b0, 1'b0);
    chk_alu("or",    OP_OR,   32'hF0F01234, 32'h0FF0FFFF, 32'hFFF0FFFF, 1'b0, 1'b0, 1'b0);
    chk_alu("nor",   OP_NOR,  32'hF0F01234, 32'h0FF0FFFF, 32'h000F0000, 1'b0, 1'b0, 1'b0);

    chk_mul("mulmax", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    chk_mul("mulhi",  32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b1);
    chk_mul("mulsm",  32'h00000003, 32'h00000005, 32'h00000000, 32'h0000000F, 1'b0);

    // Illegal opcodes complete with Err and a zero result.
    issue(4'b1111, 32'h12345678, 32'h9ABCDEF0);
    check("ill_valid", 64'(out_valid), 64'd1);
    check("ill_err",   64'(Err),       64'd1);
    check("ill_res",   64'(Result),    64'd0);
    check("ill_hi",    64'(ResultHi),  64'd0);
    check("ill_zero",  64'(Zero),      64'd1);
    issue(4'b1010, 32'h1, 32'h1);
    check("ill2_err",  64'(Err),       64'd1);

    // Backpressure: result held, second op stalled until out_ready rises.
    tick();
    out_ready = 1'b0;
    issue(OP_ADD, 32'd2, 32'd3);
    check("bp_res1", 64'(Result), 64'd5);
    Op = OP_SUB; A = 32'd9; B = 32'd7; in_valid = 1'b1;
    check("bp_rdy_low", 64'(in_ready), 64'd0);
    tick();
    tick();
    check("bp_hold_valid", 64'(out_valid), 64'd1);
    check("bp_hold_res",   64'(Result),    64'd5);
    check("bp_rdy_low2",   64'(in_ready),  64'd0);
    out_ready = 1'b1;
    #1;
    check("bp_rdy_high", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check("bp_res2_valid", 64'(out_valid), 64'd1);
    check("bp_res2",       64'(Result),    64'd2);
    tick();
    check("bp_drained", 64'(out_valid), 64'd0);

    // Reset at cycle 10 of a MUL aborts it.
    issue(OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (9) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    vcount = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) vcount++;
      tick();
    end
    check("abort_no_valid", 64'(vcount),   64'd0);
    check("abort_ready",    64'(in_ready), 64'd1);
    chk_alu("post", OP_ADD, 32'd10, 32'd20, 32'd30, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, multi-cycle successor to the 32-bit ripple ALU used by the datapath.
- Same textbook 4-bit opcode map, with shifts, unsigned compare, signed overflow and an iterative shift-add multiplier added.
- Operands and results pass through valid/ready handshakes, so the block sits between decode/issue and writeback and can stall the pipe during multiplies.

Parameters:
- WIDTH, 32: operand/result width; must be ≥4 and a power of two.
- SHW, $clog2(WIDTH): shift-amount bits taken from B[SHW-1:0]; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operands/opcode valid.
- in_ready  out  1  block can accept an operation.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- Op  in  4  opcode.
- out_valid  out  1  result registers valid.
- out_ready  in  1  consumer takes result.
- Result  out  WIDTH  result (low word for MUL).
- ResultHi  out  WIDTH  high product word for MUL; 0 for all other ops.
- Zero  out  1  Result == 0.
- Cout  out  1  carry out, ADD/SUB only, else 0.
- Ovf  out  1  signed overflow, ADD/SUB only, else 0.
- Err  out  1  illegal opcode.

Behaviour:
- Opcodes:
  - 0000 AND; 0001 OR; 0010 ADD; 0110 SUB (A+~B+1).
  - 0111 SLT signed; 1001 SLTU; 1100 NOR.
  - 0011 SLL; 0100 SRL; 0101 SRA (amount B[SHW-1:0]).
  - 1000 MUL unsigned, full 2*WIDTH product.
  - All others are illegal.
- Accept rule: operation accepted on the cycle `in_valid && in_ready`.
  - `in_ready = (state==IDLE) && (!out_valid || out_ready)`.
  - A, B and Op are sampled only on accept.
- State machine: IDLE, MUL.
  - IDLE, single-cycle op accepted: Result and flags registered; out_valid=1 the next cycle (latency 1). Back-to-back issue is possible when out_ready=1.
  - IDLE, MUL accepted: go to MUL and load multiplicand, multiplier and a zero accumulator. One shift-add per cycle for WIDTH cycles.
  - Final MUL iteration: write {ResultHi, Result}, set out_valid, return to IDLE. Latency WIDTH+1 cycles from accept to out_valid; in_ready=0 throughout MUL.
- Output hold: out_valid stays 1 and all outputs stay stable until out_ready=1.
  - out_valid=0 with out_ready=1 is a no-op.
  - Accept and drain in the same cycle: the new result replaces the old; out_valid stays 1.
- ADD/SUB flags:
  - Cout = carry out of the MSB; for SUB, Cout=1 iff A≥B unsigned.
  - Ovf = operand sign bits agree (after B inversion for SUB) and the result sign differs.
- SLT result is 1 iff (N xor V) of A−B, i.e. correct across overflow. SLT and SLTU give Result[0] only; upper bits 0.
- SRA replicates A[WIDTH-1]. Shift amount 0 gives A.
- Illegal opcode: Result=0, ResultHi=0, Zero=1, Err=1; completes with latency 1, not dropped.
- Zero is computed from Result only, never ResultHi.
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; out_valid=0; Result, ResultHi, Cout, Ovf, Err=0; Zero=1.
  - in_ready=1 after reset is released.
  - Reset during MUL aborts the operation; no result is produced.
- in_valid while in_ready=0 is ignored. Upstream must hold its request.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams (OP_AND … OP_MUL);
  - state enum;
  - function is_legal_op.
- Sub-module alu_mul_iter holds the iterative shift-add multiplier with a start/done pair and a WIDTH-cycle counter.
- Single-cycle ops stay inline as one combinational case in alu_mc.

Test Plan (WIDTH=32):
- ADD A=0x7FFFFFFF B=1 → Result=0x80000000, Ovf=1, Cout=0, Zero=0, one cycle after accept.
- SUB A=5 B=5 → Result=0, Zero=1, Cout=1. SLT A=0x80000000 B=1 → Result=1. SLTU with the same operands → Result=0.
- SRA A=0x80000000 B=31 → Result=0xFFFFFFFF. SLL A=1 B=0x20 (amount 0) → Result=1.
- MUL A=0xFFFFFFFF B=0xFFFFFFFF:
  - ResultHi=0xFFFFFFFE, Result=0x00000001 after exactly 33 cycles;
  - in_ready=0 throughout.
- Backpressure: hold out_ready=0 after an ADD; second op presented → in_ready=0, first result stable. Raise out_ready → second op accepted in the same cycle.
- Op=1111 → Err=1, Result=0. Assert rst_n=0 at cycle 10 of a MUL → out_valid never rises, in_ready=1 after release.
